// File: rtl/cmp_lgez_seq_pkg.sv
// Shared LGEZ code definitions and the word-fold rule used by the sequential comparator.
package cmp_lgez_seq_pkg;

  localparam logic [1:0] CMP_EQ_Z    = 2'b00;
  localparam logic [1:0] CMP_LESS    = 2'b01;
  localparam logic [1:0] CMP_GREATER = 2'b10;
  localparam logic [1:0] CMP_EQ_NZ   = 2'b11;

  // Once a more-significant word has decided the order, later words cannot change it.
  function automatic logic [1:0] cmp_fold(input logic [1:0] acc, input logic [1:0] c);
    logic [1:0] res;
    res = acc;
    if ((acc == CMP_LESS) || (acc == CMP_GREATER)) begin
      res = acc;
    end else if ((c == CMP_LESS) || (c == CMP_GREATER)) begin
      res = c;
    end else if (c == CMP_EQ_NZ) begin
      res = CMP_EQ_NZ;
    end
    return res;
  endfunction

endpackage

// File: rtl/cmp_lgez_seq_word.sv
// Combinational per-word LGEZ comparator: {o_rx,o_ry} = 00 zero, 01 X<Y, 10 X>Y, 11 equal nonzero.
module CmpLgezNBit
  import cmp_lgez_seq_pkg::*;
#(
  parameter int p_WIDTH = 4
) (
  input  logic [p_WIDTH-1:0] i_x,
  input  logic [p_WIDTH-1:0] i_y,
  output logic               o_rx,
  output logic               o_ry
);

  logic [1:0] w_code;

  always_comb begin
    w_code = CMP_EQ_Z;
    if (i_x > i_y) begin
      w_code = CMP_GREATER;
    end else if (i_x < i_y) begin
      w_code = CMP_LESS;
    end else if (i_x != '0) begin
      w_code = CMP_EQ_NZ;
    end
  end

  assign o_rx = w_code[1];
  assign o_ry = w_code[0];

endmodule

// File: rtl/cmp_lgez_seq.sv
// Multi-word LGEZ comparator: folds MSW-first word codes into one result held until i_ready.
// o_valid rises on the edge accepting the last word; outputs decode from registered state only.
module cmp_lgez_seq
  import cmp_lgez_seq_pkg::*;
#(
  parameter int p_WIDTH = 4,
  parameter int p_WORDS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [p_WIDTH-1:0] i_x,
  input  logic [p_WIDTH-1:0] i_y,
  input  logic               i_valid,
  output logic               o_ready,
  output logic               o_valid,
  input  logic               i_ready,
  output logic               o_rx,
  output logic               o_ry
);

  localparam int         CW   = $clog2(p_WORDS);
  localparam logic [CW-1:0] LAST = CW'(p_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [1:0]    r_acc, w_acc_nxt;
  logic          w_rx, w_ry;
  logic          w_accept;

  CmpLgezNBit #(.p_WIDTH(p_WIDTH)) u_word (
    .i_x  (i_x),
    .i_y  (i_y),
    .o_rx (w_rx),
    .o_ry (w_ry)
  );

  assign w_accept = i_valid && (r_state != S_DONE);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    case (r_state)
      S_IDLE, S_ACC: begin
        if (w_accept) begin
          w_acc_nxt = cmp_fold(r_acc, {w_rx, w_ry});
          if (r_cnt == LAST) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ACC;
            w_cnt_nxt   = r_cnt + 1'b1;
          end
        end
      end
      S_DONE: begin
        if (i_ready) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_acc_nxt   = CMP_EQ_Z;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
        w_acc_nxt   = CMP_EQ_Z;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= CMP_EQ_Z;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  assign o_ready = (r_state != S_DONE);
  assign o_valid = (r_state == S_DONE);
  assign o_rx    = o_valid & r_acc[1];
  assign o_ry    = o_valid & r_acc[0];

endmodule

// File: tb/tb_cmp_lgez_seq.sv
// Directed bench for cmp_lgez_seq with 3-bit words, 3 words per operand.
module tb_cmp_lgez_seq;
  import cmp_lgez_seq_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [2:0] i_x, i_y;
  logic       i_valid, i_ready;
  logic       o_ready, o_valid, o_rx, o_ry;
  int         checks;
  int         failures;

  cmp_lgez_seq #(.p_WIDTH(3), .p_WORDS(3)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_x     (i_x),
    .i_y     (i_y),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_rx    (o_rx),
    .o_ry    (o_ry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic rdy, input logic vld, input logic [1:0] code);
    chk({tag, "_ready"}, {31'd0, o_ready}, {31'd0, rdy});
    chk({tag, "_valid"}, {31'd0, o_valid}, {31'd0, vld});
    chk({tag, "_code"}, {30'd0, o_rx, o_ry}, {30'd0, code});
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send_beat(input string tag, input logic [2:0] x, input logic [2:0] y);
    i_x     = x;
    i_y     = y;
    i_valid = 1'b1;
    chk({tag, "_rdy_before"}, {31'd0, o_ready}, 32'd1);
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic send_op(input string tag, input logic [8:0] x, input logic [8:0] y,
                         input int gap, input logic [1:0] code);
    send_beat(tag, x[8:6], y[8:6]);
    repeat (gap) begin @(posedge clk); #1; end
    send_beat(tag, x[5:3], y[5:3]);
    chk_out({tag, "_mid"}, 1'b1, 1'b0, CMP_EQ_Z);
    repeat (gap) begin @(posedge clk); #1; end
    send_beat(tag, x[2:0], y[2:0]);
    chk_out({tag, "_done"}, 1'b0, 1'b1, code);
  endtask

  task automatic handshake(input string tag);
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    chk_out({tag, "_ack"}, 1'b1, 1'b0, CMP_EQ_Z);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    i_x      = '0;
    i_y      = '0;
    i_valid  = 1'b0;
    i_ready  = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_out("reset", 1'b1, 1'b0, CMP_EQ_Z);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk_out("idle", 1'b1, 1'b0, CMP_EQ_Z);

    send_op("zero", {3'd0, 3'd0, 3'd0}, {3'd0, 3'd0, 3'd0}, 0, CMP_EQ_Z);
    handshake("zero");

    send_op("less", {3'd2, 3'd1, 3'd7}, {3'd2, 3'd3, 3'd0}, 0, CMP_LESS);
    handshake("less");

    send_op("eqnz", {3'd0, 3'd5, 3'd4}, {3'd0, 3'd5, 3'd4}, 0, CMP_EQ_NZ);
    handshake("eqnz");

    send_op("greater", {3'd6, 3'd0, 3'd0}, {3'd5, 3'd7, 3'd7}, 0, CMP_GREATER);
    handshake("greater");

    send_op("gap", {3'd2, 3'd1, 3'd7}, {3'd2, 3'd3, 3'd0}, 2, CMP_LESS);
    handshake("gap");

    // Result must hold while i_ready is low and a pending word is offered.
    send_op("hold", {3'd6, 3'd0, 3'd0}, {3'd5, 3'd7, 3'd7}, 0, CMP_GREATER);
    i_x     = 3'd7;
    i_y     = 3'd0;
    i_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk_out($sformatf("hold%0d", k), 1'b0, 1'b1, CMP_GREATER);
    end
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    i_ready = 1'b0;
    i_valid = 1'b0;
    chk_out("hold_ack", 1'b1, 1'b0, CMP_EQ_Z);
    send_op("after_hold", {3'd0, 3'd0, 3'd1}, {3'd0, 3'd0, 3'd2}, 0, CMP_LESS);
    handshake("after_hold");

    // Asynchronous reset in the middle of an operand.
    send_beat("abort", 3'd1, 3'd1);
    send_beat("abort", 3'd1, 3'd1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b1, 1'b0, CMP_EQ_Z);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    send_beat("fresh", 3'd0, 3'd0);
    chk_out("fresh_first", 1'b1, 1'b0, CMP_EQ_Z);
    send_beat("fresh", 3'd0, 3'd0);
    chk_out("fresh_mid", 1'b1, 1'b0, CMP_EQ_Z);
    send_beat("fresh", 3'd1, 3'd1);
    chk_out("fresh_done", 1'b0, 1'b1, CMP_EQ_NZ);
    handshake("fresh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
